// File: rtl/i2c_timer_reg_if.sv
// ---------------------------------------------------------------------------
// i2c_timer_reg_if
// I2C slave front end for the timer slave board. Oversamples SCL/SDA with the
// system clock, runs the slave protocol FSM and keeps a small register file
// that drives the counter/FND block.
//
// Ports
//   clk          system clock (SCL is much slower, no clock stretching)
//   reset        synchronous, active-high reset
//   scl          I2C clock pin (input only)
//   sda_in       I2C data pin read-back
//   sda_oe       1 = pull SDA low, 0 = release (open drain)
//   counter      live counter value from the counter block
//   run          CTRL[0] level
//   updn         CTRL[1] level (1 = count up)
//   clr_cmd      one-clk pulse when CMD[0] is written with 1
//   load_cmd     one-clk pulse when CMD[1] is written with 1
//   set_tim_num  committed preset value (atomic on write of byte 0x7)
//
// Register map (4-bit pointer): 0x0 CTRL, 0x1 CMD, 0x4-0x7 SET shadow,
// 0x8-0xB CNT (byte 0x8 latches the whole counter into a snapshot).
// ---------------------------------------------------------------------------
module i2c_timer_reg_if #(
    parameter logic [6:0] SLV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [31:0] counter,
    output logic        run,
    output logic        updn,
    output logic        clr_cmd,
    output logic        load_cmd,
    output logic [31:0] set_tim_num
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_PTR      = 4'd3,
        ST_PTR_ACK  = 4'd4,
        ST_WDATA    = 4'd5,
        ST_WACK     = 4'd6,
        ST_RDATA    = 4'd7,
        ST_RACK     = 4'd8
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_d_r;
    logic                   sda_d_r;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise_s;
    logic                   scl_fall_s;
    logic                   start_s;
    logic                   stop_s;

    state_t                 state_r;
    state_t                 state_nxt;
    logic [3:0]             bit_cnt_r;
    logic [7:0]             shift_r;
    logic                   rw_r;
    logic                   ack_r;
    logic [3:0]             ptr_r;
    logic [1:0]             ctrl_r;
    logic [31:0]            shadow_r;
    logic [31:0]            snap_r;
    logic [31:0]            set_r;
    logic                   clr_r;
    logic                   load_r;
    logic                   sda_oe_r;

    logic [7:0]             tx_byte_s;
    logic                   rx_state_s;
    logic                   addr_done_s;
    logic                   oe_set_s;
    logic                   oe_val_s;
    logic                   wr_byte_s;
    logic                   ld_tx_s;
    logic                   ptr_ld_s;
    logic                   shift_tx_s;

    assign scl_s      = scl_sync_r[SYNC_STAGES-1];
    assign sda_s      = sda_sync_r[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_d_r;
    assign scl_fall_s = ~scl_s & scl_d_r;
    // START/STOP only count when SCL was high on both the old and new sample.
    assign start_s    = scl_s & scl_d_r & sda_d_r & ~sda_s;
    assign stop_s     = scl_s & scl_d_r & ~sda_d_r & sda_s;
    assign rx_state_s = (state_r == ST_ADDR) || (state_r == ST_PTR) || (state_r == ST_WDATA);

    // Pin synchronizers and one-flop edge history
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_r <= {SYNC_STAGES{1'b0}};
            sda_sync_r <= {SYNC_STAGES{1'b0}};
            scl_d_r    <= 1'b0;
            sda_d_r    <= 1'b0;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
            scl_d_r    <= scl_s;
            sda_d_r    <= sda_s;
        end
    end

    // Byte presented to the master for the current pointer
    always_comb begin
        tx_byte_s = 8'h00;
        case (ptr_r)
            4'h0:    tx_byte_s = {6'b000000, ctrl_r};
            4'h4:    tx_byte_s = shadow_r[7:0];
            4'h5:    tx_byte_s = shadow_r[15:8];
            4'h6:    tx_byte_s = shadow_r[23:16];
            4'h7:    tx_byte_s = shadow_r[31:24];
            4'h8:    tx_byte_s = counter[7:0];
            4'h9:    tx_byte_s = snap_r[15:8];
            4'hA:    tx_byte_s = snap_r[23:16];
            4'hB:    tx_byte_s = snap_r[31:24];
            default: tx_byte_s = 8'h00;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next state and per-clk strobes; protocol steps happen on SCL falling edges
    always_comb begin
        state_nxt   = state_r;
        oe_set_s    = 1'b0;
        oe_val_s    = 1'b0;
        addr_done_s = 1'b0;
        wr_byte_s   = 1'b0;
        ld_tx_s     = 1'b0;
        ptr_ld_s    = 1'b0;
        shift_tx_s  = 1'b0;
        if (stop_s) begin
            state_nxt = ST_IDLE;
            oe_set_s  = 1'b1;
        end else if (start_s) begin
            state_nxt = ST_ADDR;
            oe_set_s  = 1'b1;
        end else if (scl_fall_s) begin
            case (state_r)
                ST_ADDR: begin
                    if (bit_cnt_r == 4'd8) begin
                        addr_done_s = 1'b1;
                        oe_set_s    = 1'b1;
                        if (shift_r[7:1] == SLV_ADDR) begin
                            state_nxt = ST_ADDR_ACK;
                            oe_val_s  = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        state_nxt = ST_ADDR;
                    end
                end
                ST_ADDR_ACK: begin
                    oe_set_s = 1'b1;
                    if (rw_r) begin
                        state_nxt = ST_RDATA;
                        ld_tx_s   = 1'b1;
                        oe_val_s  = ~tx_byte_s[7];
                    end else begin
                        state_nxt = ST_PTR;
                    end
                end
                ST_PTR: begin
                    if (bit_cnt_r == 4'd8) begin
                        state_nxt = ST_PTR_ACK;
                        ptr_ld_s  = 1'b1;
                        oe_set_s  = 1'b1;
                        oe_val_s  = 1'b1;
                    end else begin
                        state_nxt = ST_PTR;
                    end
                end
                ST_PTR_ACK: begin
                    state_nxt = ST_WDATA;
                    oe_set_s  = 1'b1;
                end
                ST_WDATA: begin
                    if (bit_cnt_r == 4'd8) begin
                        state_nxt = ST_WACK;
                        wr_byte_s = 1'b1;
                        oe_set_s  = 1'b1;
                        oe_val_s  = 1'b1;
                    end else begin
                        state_nxt = ST_WDATA;
                    end
                end
                ST_WACK: begin
                    state_nxt = ST_WDATA;
                    oe_set_s  = 1'b1;
                end
                ST_RDATA: begin
                    oe_set_s = 1'b1;
                    if (bit_cnt_r == 4'd8) begin
                        state_nxt = ST_RACK;
                    end else begin
                        shift_tx_s = 1'b1;
                        oe_val_s   = ~shift_r[6];
                    end
                end
                ST_RACK: begin
                    oe_set_s = 1'b1;
                    if (ack_r) begin
                        state_nxt = ST_RDATA;
                        ld_tx_s   = 1'b1;
                        oe_val_s  = ~tx_byte_s[7];
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    oe_set_s  = 1'b1;
                end
            endcase
        end else begin
            state_nxt = state_r;
        end
    end

    // Shift/bit counting, pointer, register file, snapshot and SDA driver
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            rw_r      <= 1'b0;
            ack_r     <= 1'b0;
            ptr_r     <= 4'h0;
            ctrl_r    <= 2'b00;
            shadow_r  <= 32'h0000_0000;
            snap_r    <= 32'h0000_0000;
            set_r     <= 32'h0000_0000;
            clr_r     <= 1'b0;
            load_r    <= 1'b0;
            sda_oe_r  <= 1'b0;
        end else begin
            clr_r  <= 1'b0;
            load_r <= 1'b0;
            // Every state starts counting bits from zero, including a repeated START.
            if (start_s || (state_nxt != state_r)) begin
                bit_cnt_r <= 4'd0;
            end else if (scl_rise_s && (bit_cnt_r != 4'd8)) begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end
            if (scl_rise_s && rx_state_s) begin
                shift_r <= {shift_r[6:0], sda_s};
            end else if (ld_tx_s) begin
                shift_r <= tx_byte_s;
            end else if (shift_tx_s) begin
                shift_r <= {shift_r[6:0], 1'b0};
            end
            if (scl_rise_s && (state_r == ST_RACK)) begin
                ack_r <= ~sda_s;
            end
            if (addr_done_s) begin
                rw_r <= shift_r[0];
            end
            if (oe_set_s) begin
                sda_oe_r <= oe_val_s;
            end
            if (ptr_ld_s) begin
                ptr_r <= shift_r[3:0];
            end else if (ld_tx_s || wr_byte_s) begin
                ptr_r <= ptr_r + 4'd1;
            end
            // Loading CNT byte 0 freezes all four bytes so later bytes cannot tear.
            if (ld_tx_s && (ptr_r == 4'h8)) begin
                snap_r <= counter;
            end
            if (wr_byte_s) begin
                case (ptr_r)
                    4'h0: ctrl_r <= shift_r[1:0];
                    4'h1: begin
                        clr_r  <= shift_r[0];
                        load_r <= shift_r[1];
                    end
                    4'h4: shadow_r[7:0]   <= shift_r;
                    4'h5: shadow_r[15:8]  <= shift_r;
                    4'h6: shadow_r[23:16] <= shift_r;
                    4'h7: begin
                        shadow_r[31:24] <= shift_r;
                        set_r           <= {shift_r, shadow_r[23:0]};
                    end
                    default: ctrl_r <= ctrl_r;
                endcase
            end
        end
    end

    assign sda_oe      = sda_oe_r;
    assign run         = ctrl_r[0];
    assign updn        = ctrl_r[1];
    assign clr_cmd     = clr_r;
    assign load_cmd    = load_r;
    assign set_tim_num = set_r;

endmodule
